// File: rtl/m68k_bus_initiator.sv
// 68000-style asynchronous bus master: runs single-word requests as /AS-/DS bus cycles,
// waits on a synchronised /DTACK and returns read data or a bus-error flag.
module m68k_bus_initiator #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned ADDR_W  = 23
) (
    input  logic              cpu_clk,
    input  logic              cpu_nreset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    input  logic [1:0]        req_be,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_berr,
    output logic [ADDR_W-1:0] bus_a,
    output logic              bus_rw,
    output logic              bus_nas,
    output logic              bus_nuds,
    output logic              bus_nlds,
    output logic [15:0]       bus_d_out,
    output logic              bus_d_oe,
    input  logic [15:0]       bus_d_in,
    input  logic              bus_ndtack
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REJ,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4,
        ST_S5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rw_q;
    logic [1:0]          be_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                dtack_s;

    logic                accept;
    logic                timeout_hit;
    logic                rw_n;
    logic [1:0]          be_n;
    logic                strobe_on;
    logic                req_ready_d, rsp_valid_d, rsp_berr_d, bus_rw_d;
    logic                bus_nas_d, bus_nuds_d, bus_nlds_d, bus_d_oe_d;
    logic [DATA_W-1:0]   rsp_rdata_d;

    assign accept      = req_valid && (state_q == ST_IDLE);
    assign timeout_hit = (state_q == ST_S3) && !dtack_s && (cnt_q == CNT_LAST);
    assign bus_a       = addr_q;
    assign bus_d_out   = wdata_q;

    // Next state plus next values of every registered bus/response output.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata;

        case (state_q)
            ST_IDLE: if (req_valid) state_d = (req_be == 2'b00) ? ST_REJ : ST_S1;
            ST_REJ:  state_d = ST_IDLE;
            ST_S1:   state_d = ST_S2;
            ST_S2: begin
                state_d = ST_S3;
                cnt_d   = '0;
            end
            ST_S3: begin
                if (dtack_s) begin
                    state_d = ST_S4;
                    if (rw_q) rsp_rdata_d = bus_d_in;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_S4;
                    if (rw_q) rsp_rdata_d = 16'hFFFF;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_S4:   state_d = ST_S5;
            ST_S5:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        rw_n = accept ? req_rw : rw_q;
        be_n = accept ? req_be : be_q;

        // Reads strobe with /AS; writes wait one cycle for the data bus to settle.
        strobe_on   = (state_d == ST_S3) || ((state_d == ST_S2) && rw_n);
        bus_nas_d   = !((state_d == ST_S2) || (state_d == ST_S3));
        bus_nuds_d  = !(strobe_on && be_n[1]);
        bus_nlds_d  = !(strobe_on && be_n[0]);
        bus_d_oe_d  = !rw_n && (state_d inside {ST_S2, ST_S3, ST_S4});
        bus_rw_d    = (state_d inside {ST_S1, ST_S2, ST_S3, ST_S4}) ? rw_n : 1'b1;
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_S4) || (state_d == ST_REJ);
        rsp_berr_d  = (state_d == ST_REJ) || timeout_hit;
    end

    always_ff @(posedge cpu_clk or negedge cpu_nreset) begin
        if (!cpu_nreset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dtack_s   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b1;
            be_q      <= 2'b00;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_berr  <= 1'b0;
            rsp_rdata <= '0;
            bus_rw    <= 1'b1;
            bus_nas   <= 1'b1;
            bus_nuds  <= 1'b1;
            bus_nlds  <= 1'b1;
            bus_d_oe  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dtack_s   <= !bus_ndtack;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rw_q    <= req_rw;
                be_q    <= req_be;
            end
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_berr  <= rsp_berr_d;
            rsp_rdata <= rsp_rdata_d;
            bus_rw    <= bus_rw_d;
            bus_nas   <= bus_nas_d;
            bus_nuds  <= bus_nuds_d;
            bus_nlds  <= bus_nlds_d;
            bus_d_oe  <= bus_d_oe_d;
        end
    end

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Bench for m68k_bus_initiator: behavioural DTACK responder, per-transaction signal trace
// and a response scoreboard filled at request acceptance.
module tb_m68k_bus_initiator;

    localparam int unsigned ADDR_W  = 23;
    localparam int unsigned TIMEOUT = 64;

    logic              cpu_clk = 1'b0;
    logic              cpu_nreset;
    logic              req_valid, req_ready, req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic [1:0]        req_be;
    logic              rsp_valid, rsp_berr;
    logic [15:0]       rsp_rdata;
    logic [ADDR_W-1:0] bus_a;
    logic              bus_rw, bus_nas, bus_nuds, bus_nlds, bus_d_oe;
    logic [15:0]       bus_d_out, bus_d_in;
    logic              bus_ndtack;

    m68k_bus_initiator #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
        .cpu_clk(cpu_clk), .cpu_nreset(cpu_nreset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_berr(rsp_berr),
        .bus_a(bus_a), .bus_rw(bus_rw), .bus_nas(bus_nas), .bus_nuds(bus_nuds),
        .bus_nlds(bus_nlds), .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe),
        .bus_d_in(bus_d_in), .bus_ndtack(bus_ndtack)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Responder: acknowledges wait_n cycles after /AS falls and returns an address-derived word.
    logic        resp_en = 1'b1;
    int unsigned wait_n  = 0;
    int unsigned as_cnt  = 0;

    function automatic logic [15:0] resp_data(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'hE000;
    endfunction

    always @(posedge cpu_clk) begin
        if (bus_nas) as_cnt <= 0;
        else         as_cnt <= as_cnt + 1;
    end

    assign bus_ndtack = !(resp_en && !bus_nas && (as_cnt >= wait_n));
    assign bus_d_in   = resp_data(bus_a);

    typedef struct packed {
        logic              rd;
        logic              rej;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       rdata;
        logic              berr;
    } exp_t;

    exp_t        exp_q[$];
    logic        exp_to      = 1'b0;
    logic [15:0] model_rdata = 16'h0000;
    int          acc_cnt     = 0;

    logic [6:0]        tr_cyc   = 7'd0;
    logic [127:0]      t_nas    = '1;
    logic [127:0]      t_nuds   = '1;
    logic [127:0]      t_nlds   = '1;
    logic [127:0]      t_oe     = '0;
    logic [127:0]      t_rdy    = '0;
    logic [127:0]      t_rw     = '1;
    int                rsp_cyc  = -1;
    logic [ADDR_W-1:0] rec_a    = '0;
    logic [15:0]       rec_dout = '0;

    // Monitor: trace relative to the accepting cycle, push on accept, pop on response.
    always @(negedge cpu_clk) begin
        exp_t e;
        if (!cpu_nreset) begin
            chk("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
        end else begin
            if (req_valid && req_ready) begin
                tr_cyc = 7'd0;
                t_nas = '1; t_nuds = '1; t_nlds = '1; t_oe = '0; t_rdy = '0; t_rw = '1;
                rsp_cyc = -1;
                e.rd   = req_rw;
                e.rej  = (req_be == 2'b00);
                e.addr = req_addr;
                if (e.rej) begin
                    e.berr  = 1'b1;
                    e.rdata = model_rdata;
                end else begin
                    e.berr = exp_to;
                    if (req_rw) begin
                        e.rdata     = exp_to ? 16'hFFFF : resp_data(req_addr);
                        model_rdata = e.rdata;
                    end else begin
                        e.rdata = model_rdata;
                    end
                end
                exp_q.push_back(e);
                acc_cnt++;
            end else if (tr_cyc != 7'd127) begin
                tr_cyc = tr_cyc + 7'd1;
            end
            t_nas[tr_cyc]  = bus_nas;
            t_nuds[tr_cyc] = bus_nuds;
            t_nlds[tr_cyc] = bus_nlds;
            t_oe[tr_cyc]   = bus_d_oe;
            t_rdy[tr_cyc]  = req_ready;
            t_rw[tr_cyc]   = bus_rw;
            if (tr_cyc == 7'd1) rec_a = bus_a;
            if (tr_cyc == 7'd3) rec_dout = bus_d_out;
            if (rsp_valid) begin
                rsp_cyc = int'(tr_cyc);
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_berr", 32'(rsp_berr), 32'(e.berr));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    if (!e.rej) chk("rsp_addr", 32'(bus_a), 32'(e.addr));
                end
            end
            if (bus_nas) chk("strobe_without_as", 32'({bus_nuds, bus_nlds}), 32'd3);
        end
    end

    task automatic do_req(input logic rw, input logic [ADDR_W-1:0] a,
                          input logic [15:0] wd, input logic [1:0] be);
        int n;
        @(posedge cpu_clk); #1;
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = wd; req_be = be;
        n = 0;
        @(negedge cpu_clk);
        while (!req_ready && n < 50) begin
            @(negedge cpu_clk);
            n++;
        end
        if (!req_ready) chk("req_accept", 32'd0, 32'd1);
        @(posedge cpu_clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!(req_ready && exp_q.size() == 0) && n < 300) begin
            @(posedge cpu_clk);
            n++;
        end
        chk({tag, "_done"}, 32'(req_ready && (exp_q.size() == 0)), 32'd1);
        repeat (3) @(posedge cpu_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc0;
        cpu_nreset = 1'b0;
        req_valid = 1'b0; req_rw = 1'b1; req_addr = '0; req_wdata = '0; req_be = 2'b00;
        repeat (3) @(negedge cpu_clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp", 32'({rsp_valid, rsp_berr, rsp_rdata}), 32'd0);
        chk("rst_strobes", 32'({bus_nas, bus_nuds, bus_nlds, bus_rw}), 32'hF);
        chk("rst_bus_oe", 32'(bus_d_oe), 32'd0);
        chk("rst_bus_a_dout", 32'(bus_a) | 32'(bus_d_out), 32'd0);
        #1 cpu_nreset = 1'b1;

        // Zero-wait read of autoconfig $E80000.
        do_req(1'b1, 23'h740000, 16'h0000, 2'b11);
        wait_done("rd_ac");
        chk("rd_ac_bus_a", 32'(rec_a), 32'h740000);
        chk("rd_ac_as_s1_s2", 32'(t_nas[2:1]), 32'b01);
        chk("rd_ac_ds_s2", 32'({t_nuds[2], t_nlds[2]}), 32'd0);
        chk("rd_ac_rsp_cyc", 32'(rsp_cyc), 32'd4);
        chk("rd_ac_ready", 32'(t_rdy[6:5]), 32'b10);

        // Upper-byte write to $E80048.
        do_req(1'b0, 23'h740024, 16'h1234, 2'b10);
        wait_done("wr_ac");
        chk("wr_nlds_high", 32'(t_nlds[9:0]), 32'h3FF);
        chk("wr_nuds_s3_only", 32'(t_nuds[7:0]), 32'hF7);
        chk("wr_oe_s2_s4", 32'(t_oe[7:0]), 32'h1C);
        chk("wr_rw", 32'(t_rw[6:0]), 32'h61);
        chk("wr_dout", 32'(rec_dout), 32'h1234);
        chk("wr_rsp_cyc", 32'(rsp_cyc), 32'd4);

        // No responder at $A00000: bus error after the full wait window.
        resp_en = 1'b0; exp_to = 1'b1;
        do_req(1'b1, 23'h500000, 16'h0000, 2'b11);
        wait_done("to");
        chk("to_rsp_cyc", 32'(rsp_cyc), 32'd67);
        chk("to_as_low_cycles", 32'($countones(~t_nas)), 32'd65);
        chk("to_as_released", 32'(t_nas[67]), 32'd1);

        // DTACK seen on the very last wait cycle beats the timeout.
        resp_en = 1'b1; exp_to = 1'b0; wait_n = 63;
        do_req(1'b1, 23'h512345, 16'h0000, 2'b11);
        wait_done("edge");
        chk("edge_rsp_cyc", 32'(rsp_cyc), 32'd67);

        // Empty byte-enable request is rejected without a bus cycle.
        wait_n = 0;
        do_req(1'b1, 23'h300000, 16'h0000, 2'b00);
        wait_done("rej");
        chk("rej_rsp_cyc", 32'(rsp_cyc), 32'd1);
        chk("rej_ready", 32'(t_rdy[2:1]), 32'b10);
        chk("rej_no_as", 32'($countones(~t_nas[7:0])), 32'd0);

        // Continuous request stream against a 3-wait responder.
        wait_n = 3;
        acc0 = acc_cnt;
        @(posedge cpu_clk); #1;
        req_valid = 1'b1; req_rw = 1'b1; req_be = 2'b11; req_wdata = '0;
        for (int k = 0; k < 4; k++) begin
            req_addr = 23'h200000 + 23'(k * 16'h111);
            n = 0;
            do begin
                @(negedge cpu_clk);
                n++;
            end while (!req_ready && n < 50);
            if (k > 0) chk("stream_spacing", 32'(n), 32'd9);
            @(posedge cpu_clk); #1;
        end
        req_valid = 1'b0;
        wait_done("stream");
        chk("stream_accepts", 32'(acc_cnt - acc0), 32'd4);

        // Reset asserted while a write is waiting in S3.
        resp_en = 1'b0; exp_to = 1'b1;
        do_req(1'b0, 23'h100000, 16'hABCD, 2'b11);
        n = 0;
        while (bus_nuds && n < 50) begin
            @(negedge cpu_clk);
            n++;
        end
        chk("rst_mid_nuds_seen", 32'(bus_nuds), 32'd0);
        #2 cpu_nreset = 1'b0;
        #1;
        chk("rst_mid_strobes", 32'({bus_nas, bus_nuds, bus_nlds}), 32'h7);
        chk("rst_mid_oe", 32'(bus_d_oe), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_q.delete();
        model_rdata = 16'h0000;
        resp_en = 1'b1; exp_to = 1'b0; wait_n = 1;
        repeat (2) @(negedge cpu_clk);
        #2 cpu_nreset = 1'b1;
        do_req(1'b1, 23'h7400AB, 16'h0000, 2'b11);
        wait_done("post_rst");
        chk("post_rst_rsp_cyc", 32'(rsp_cyc), 32'd5);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/m68k_bus_initiator.md
Name: m68k_bus_initiator

Overview:
- Synthesizable 68000-style asynchronous-bus master: takes single-word transaction requests from an internal requester and runs them as bus cycles.
- Drives A[23:1], /AS, /UDS, /LDS, R/W and the data bus; waits for /DTACK; returns read data or a bus-error flag.
- Sits opposite the expansion-RAM/autoconfig responder on the same bus: used by the on-board test sequencer to probe autoconfig space ($E8xxxx) and exercise DRAM at $200000-$9FFFFF.

Parameters:
TIMEOUT, 64, max cycles spent in WAIT without /DTACK before bus error; legal 2..255
ADDR_W, 23, width of word address (A[23:1])

Ports:
cpu_clk  in  1  clock; all state changes on rising edge
cpu_nreset  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  block idle, request accepted when req_valid&req_ready
req_rw  in  1  1=read, 0=write
req_addr  in  ADDR_W  word address
req_wdata  in  16  write data
req_be  in  2  byte enables {upper,lower}; maps to {/UDS,/LDS}
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  16  read data, held until next response
rsp_berr  out  1  valid with rsp_valid: timeout or illegal request
bus_a  out  ADDR_W  address bus
bus_rw  out  1  R/W
bus_nas  out  1  /AS
bus_nuds  out  1  /UDS
bus_nlds  out  1  /LDS
bus_d_out  out  16  write data
bus_d_oe  out  1  data bus output enable
bus_d_in  in  16  read data from bus
bus_ndtack  in  1  /DTACK, active-low, external

Behaviour:
- Reset (async, cpu_nreset=0): state IDLE; req_ready=1; rsp_valid=0; rsp_berr=0; rsp_rdata=0; bus_nas=bus_nuds=bus_nlds=1; bus_rw=1; bus_d_oe=0; bus_a=0; bus_d_out=0; timeout counter=0; dtack_s=0. Reset mid-cycle aborts immediately with no response.
- dtack_s: one register stage of ~bus_ndtack. All DTACK decisions use dtack_s only.
- Request latch: on accept, addr/rw/wdata/be are registered. bus_a, bus_rw and bus_d_out come from these registers and stay stable through RECOV.
- IDLE: req_ready=1, bus at idle levels.
  - Accept with req_be=00: go to REJ.
  - Any other accept: go to S1.
- REJ (1 cycle): rsp_valid=1, rsp_berr=1; no strobe asserted. Next state IDLE.
- S1 (1 cycle): bus_a and bus_rw driven; /AS=1. Next S2.
- S2 (1 cycle):
  - /AS=0.
  - Read: /UDS=~be[1], /LDS=~be[0].
  - Write: bus_d_oe=1, strobes still high.
  - Counter cleared. Next S3.
- S3 WAIT:
  - Write: strobes asserted per be.
  - If dtack_s=1: go to S4; read latches bus_d_in into rsp_rdata on that edge.
  - Else: counter+1. If counter==TIMEOUT-1, go to S4 with berr set; rsp_rdata becomes FFFF on reads, unchanged on writes.
  - S3 lasts at most TIMEOUT cycles.
- S4 DONE (1 cycle): /AS, /UDS, /LDS=1; rsp_valid=1; rsp_berr per outcome; bus_d_oe is held for data hold. Next S5.
- S5 RECOV (1 cycle): bus_d_oe=0, bus_rw=1. Next IDLE.
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored (not queued).
- Latency with zero-wait responder (DTACK asserted during S2): accept at edge 0 → S1 cycle 1, S2 cycle 2, S3 cycle 3, rsp_valid in cycle 4, req_ready=1 in cycle 6. Back-to-back throughput is 1 transaction per 6 cycles.
- /DTACK already low at S2 (stuck responder): treated as valid acknowledge.
- /DTACK asserting on the same edge as the timeout: DTACK wins, berr=0.
- /AS never low outside S2–S3; /UDS and /LDS never low while /AS high.

Test Plan:
- Read $E80000, be=11, responder DTACK in S2 returning D=E000 → bus_a=0x740000, /UDS,/LDS low in S2; rsp_valid in cycle 4, rsp_rdata=E000, rsp_berr=0.
- Write $E80048 data=0x1234, be=10 → /LDS stays high throughout; /UDS low only in S3; bus_d_oe high in S2–S4; bus_d_out=1234; rsp_berr=0.
- Read $A00000 with no DTACK, TIMEOUT=64 → S3 exactly 64 cycles; rsp_valid with rsp_berr=1, rsp_rdata=FFFF; /AS released in S4.
- Request be=00 → no /AS assertion; rsp_valid next cycle with berr=1; req_ready back after 2 cycles.
- Responder with 3 wait cycles; req_valid held high continuously → only one cycle per 6+3 clocks; each response carries the matching address; req_valid during busy is not double-accepted.
- Assert cpu_nreset low in S3 of a write → same-cycle /AS,/UDS,/LDS=1, bus_d_oe=0, no rsp_valid; after release, a new read completes normally.
